piezo_decode: RTL

PIEZO_DECODE -- requirements
Module: piezo_decode

---
 rtl/piezo_pkg.sv | 99 +++++++++
 rtl/piezo_period_meas.sv | 41 ++++
 rtl/piezo_decode.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/piezo_pkg.sv
// Types, timing constants and melody tables for the piezo tone decoder.
// Build option: PIEZO_DECODE_LEN_CHK_EN adds a +/-1 unit length check to pattern matching.
package piezo_pkg;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_G6   = 3'd1,
        NOTE_C7   = 3'd2,
        NOTE_E7   = 3'd3,
        NOTE_G7   = 3'd4
    } note_t;

    typedef enum logic [1:0] {
        PAT_NONE     = 2'b00,
        PAT_FANFARE  = 2'b01,
        PAT_TOO_FAST = 2'b10,
        PAT_BATT_LOW = 2'b11
    } pat_t;

    localparam int HP_W   = 17;
    localparam int DUR_W  = 27;
    localparam int HIST_N = 6;

    localparam logic [HP_W-1:0]  HP_MAX      = {HP_W{1'b1}};
    localparam logic [HP_W-1:0]  SILENCE_CNT = 17'd65536;
    localparam logic [DUR_W-1:0] DUR_MAX     = {DUR_W{1'b1}};
    localparam logic [DUR_W:0]   LEN_HALF    = 28'd2097152;

    localparam logic [HP_W-1:0] G6_LO = 17'd15000;
    localparam logic [HP_W-1:0] G6_HI = 17'd16900;
    localparam logic [HP_W-1:0] C7_LO = 17'd11000;
    localparam logic [HP_W-1:0] C7_HI = 17'd12900;
    localparam logic [HP_W-1:0] E7_LO = 17'd8800;
    localparam logic [HP_W-1:0] E7_HI = 17'd10300;
    localparam logic [HP_W-1:0] G7_LO = 17'd7400;
    localparam logic [HP_W-1:0] G7_HI = 17'd8700;

`ifdef PIEZO_DECODE_LEN_CHK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    typedef struct packed {
        note_t      id;
        logic [3:0] len;
    } hist_ent_t;

    typedef hist_ent_t [HIST_N-1:0] hist_t;
    typedef logic [HIST_N-1:0][2:0] pat_ids_t;
    typedef logic [HIST_N-1:0][3:0] pat_lens_t;

    // Tables are indexed newest-first: entry 0 is the note that just ended.
    localparam pat_ids_t  FANFARE_IDS   = {3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    localparam pat_lens_t FANFARE_LENS  = {4'd2, 4'd2, 4'd2, 4'd3, 4'd1, 4'd8};
    localparam pat_ids_t  BATT_IDS      = {3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};
    localparam pat_lens_t BATT_LENS     = {4'd8, 4'd1, 4'd3, 4'd2, 4'd2, 4'd2};
    localparam pat_ids_t  TOO_FAST_IDS  = {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd1};
    localparam pat_lens_t TOO_FAST_LENS = {4'd0, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0};

    localparam logic [HIST_N-1:0] MASK_ALL      = 6'b111111;
    localparam logic [HIST_N-1:0] TOO_FAST_ENT  = 6'b001111;
    localparam logic [HIST_N-1:0] TOO_FAST_LEN  = 6'b001110;

    function automatic note_t classify(input logic [HP_W-1:0] cnt);
        note_t n;
        if (cnt >= G6_LO && cnt <= G6_HI)      n = NOTE_G6;
        else if (cnt >= C7_LO && cnt <= C7_HI) n = NOTE_C7;
        else if (cnt >= E7_LO && cnt <= E7_HI) n = NOTE_E7;
        else if (cnt >= G7_LO && cnt <= G7_HI) n = NOTE_G7;
        else                                   n = NOTE_NONE;
        return n;
    endfunction

    function automatic logic [3:0] round_len(input logic [DUR_W-1:0] dur);
        logic [5:0] q;
        q = 6'(({1'b0, dur} + LEN_HALF) >> 22);
        return (q > 6'd15) ? 4'd15 : q[3:0];
    endfunction

    function automatic logic len_near(input logic [3:0] got, input logic [3:0] want);
        return ({1'b0, got} + 5'd1 >= {1'b0, want}) && ({1'b0, got} <= {1'b0, want} + 5'd1);
    endfunction

    function automatic logic pat_match(input hist_t h, input pat_ids_t ids, input pat_lens_t lens,
                                       input logic [HIST_N-1:0] ent_mask,
                                       input logic [HIST_N-1:0] len_mask);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < HIST_N; i++) begin
            if (ent_mask[i] && (h[i].id != ids[i]))
                ok = 1'b0;
            if (LEN_CHK && ent_mask[i] && len_mask[i] && !len_near(h[i].len, lens[i]))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/piezo_period_meas.sv
// Synchronises the piezo input, detects edges and classifies each half-period
// against the note windows; also flags silence when no edge arrives for too long.
module piezo_period_meas
    import piezo_pkg::*;
#(
    parameter bit fast_sim = 1'b0
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  piezo,
    output logic  edge_evt,
    output note_t id,
    output logic  silence
);

    localparam logic [HP_W-1:0] STEP = fast_sim ? 17'd64 : 17'd1;

    // [1:0] form the synchroniser, [2] is the previous synchronised value
    logic [2:0]      sync_q;
    logic [HP_W-1:0] hp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hp_cnt <= '0;
        end else begin
            sync_q <= {sync_q[1:0], piezo};
            if (edge_evt)
                hp_cnt <= '0;
            else if (hp_cnt > HP_MAX - STEP)
                hp_cnt <= HP_MAX;
            else
                hp_cnt <= hp_cnt + STEP;
        end
    end

    assign edge_evt = sync_q[2] ^ sync_q[1];
    assign id       = classify(hp_cnt);
    assign silence  = (hp_cnt >= SILENCE_CNT);

endmodule

// File: rtl/piezo_decode.sv
// Piezo melody decoder: confirms notes, reports their lengths and recognises melodies.
// Build option: PIEZO_DECODE_LEN_CHK_EN makes melody matching also check note lengths.
//
// state   | meaning
// ST_IDLE | no note in progress, waiting for two matching half-periods
// ST_NOTE | confirmed note sounding, duration counter running
module piezo_decode
    import piezo_pkg::*;
#(
    parameter bit fast_sim = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       piezo,
    output logic       note_vld,
    output logic [2:0] note_id,
    output logic [3:0] note_len,
    output logic       pat_vld,
    output logic [1:0] pat,
    output logic       active
);

    localparam logic [DUR_W-1:0] DSTEP = fast_sim ? 27'd64 : 27'd1;

    typedef enum logic {ST_IDLE, ST_NOTE} state_t;

    state_t           state, state_nxt;
    logic             edge_evt, silence;
    note_t            meas_id, cand_id, cur_id;
    logic [DUR_W-1:0] dur;
    logic             note_start, note_end, end_clr;
    logic             clr_q, hist_clr_q;
    hist_ent_t        new_ent;
    hist_t            hist, hist_nxt;
    pat_t             pat_sel;

    piezo_period_meas #(.fast_sim(fast_sim)) u_meas (
        .clk      (clk),
        .rst_n    (rst_n),
        .piezo    (piezo),
        .edge_evt (edge_evt),
        .id       (meas_id),
        .silence  (silence)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (edge_evt && meas_id != NOTE_NONE && meas_id == cand_id)
                         state_nxt = ST_NOTE;
            ST_NOTE: if (silence || (edge_evt && meas_id == NOTE_NONE))
                         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        note_start = 1'b0;
        note_end   = 1'b0;
        end_clr    = 1'b0;
        active     = (state == ST_NOTE);
        case (state)
            ST_IDLE: note_start = edge_evt && meas_id != NOTE_NONE && meas_id == cand_id;
            ST_NOTE: begin
                if (silence || (edge_evt && meas_id == NOTE_NONE)) begin
                    note_end = 1'b1;
                    end_clr  = 1'b1;
                end else if (edge_evt && meas_id != cur_id && meas_id == cand_id) begin
                    note_end   = 1'b1;
                    note_start = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_id  <= NOTE_NONE;
            cur_id   <= NOTE_NONE;
            dur      <= '0;
            note_vld <= 1'b0;
            note_id  <= '0;
            note_len <= '0;
            clr_q    <= 1'b0;
        end else begin
            if (edge_evt)
                cand_id <= meas_id;
            if (note_start) begin
                cur_id <= meas_id;
                dur    <= '0;
            end else if (state == ST_NOTE) begin
                dur <= (dur > DUR_MAX - DSTEP) ? DUR_MAX : dur + DSTEP;
            end
            note_vld <= note_end;
            clr_q    <= note_end & end_clr;
            if (note_end) begin
                note_id  <= cur_id;
                note_len <= round_len(dur);
            end
        end
    end

    // Matching looks at the history as it will be once the new note is shifted in.
    always_comb begin
        new_ent.id  = note_t'(note_id);
        new_ent.len = note_len;
        hist_nxt    = {hist[HIST_N-2:0], new_ent};
        if (pat_match(hist_nxt, FANFARE_IDS, FANFARE_LENS, MASK_ALL, MASK_ALL))
            pat_sel = PAT_FANFARE;
        else if (pat_match(hist_nxt, BATT_IDS, BATT_LENS, MASK_ALL, MASK_ALL))
            pat_sel = PAT_BATT_LOW;
        else if (pat_match(hist_nxt, TOO_FAST_IDS, TOO_FAST_LENS, TOO_FAST_ENT, TOO_FAST_LEN))
            pat_sel = PAT_TOO_FAST;
        else
            pat_sel = PAT_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist       <= '0;
            hist_clr_q <= 1'b0;
            pat_vld    <= 1'b0;
            pat        <= '0;
        end else begin
            hist_clr_q <= note_vld & clr_q;
            if (note_vld)
                hist <= hist_nxt;
            else if (hist_clr_q)
                hist <= '0;
            pat_vld <= note_vld && (pat_sel != PAT_NONE);
            if (note_vld && pat_sel != PAT_NONE)
                pat <= pat_sel;
        end
    end

endmodule
